multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_pkg.sv | 32 +++
 rtl/multdiv_addsub.sv | 26 ++
 rtl/multdiv_unit.sv | 208 ++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared constants for the iterative multiply/divide unit:
//                FSM state encoding, iteration count, operation-type
//                encoding and a two's-complement magnitude helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    // One iteration per result bit
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Operation-type encoding
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Magnitude of a signed 32-bit value. 0x80000000 maps onto itself,
    // which read as unsigned is the correct magnitude 2^31.
    function automatic logic [31:0] f_abs(input logic [31:0] i_x);
        return i_x[31] ? (~i_x + 32'd1) : i_x;
    endfunction

endpackage : multdiv_pkg
`default_nettype wire

// File: rtl/multdiv_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_addsub
//  Description : 33-bit adder/subtractor shared by the multiply (accumulate)
//                and divide (trial subtract) iterations.
//  Ports       : i_a   - minuend / augend
//                i_b   - subtrahend / addend
//                i_sub - 1 = i_a - i_b, 0 = i_a + i_b
//                o_sum - 33-bit result (modulo 2^33)
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_addsub (
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    input  logic        i_sub,
    output logic [32:0] o_sum
);

    logic [32:0] w_b_inv;

    // Subtract as a + ~b + 1 so a single carry chain serves both operations
    assign w_b_inv = i_b ^ {33{i_sub}};
    assign o_sum   = i_a + w_b_inv + {32'd0, i_sub};

endmodule : multdiv_addsub
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_unit
//  Description : Iterative signed 32-bit multiplier / divider. A start pulse
//                on ctrl_MULT or ctrl_DIV (not both) captures the operands;
//                32 iteration cycles later data_resultRDY pulses for one
//                cycle with the result and exception flag.
//  Ports       : clock           - rising-edge clock
//                reset           - asynchronous active-low reset
//                data_operandA   - multiplicand / dividend (signed)
//                data_operandB   - multiplier / divisor (signed)
//                ctrl_MULT       - multiply start pulse
//                ctrl_DIV        - divide start pulse
//                data_result     - signed result, held until next completion
//                data_exception  - overflow / divide-by-zero flag
//                data_resultRDY  - one-cycle result-valid pulse
//                busy            - high while iterating
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic [31:0]      r_mag;      // |multiplicand| or |divisor|
    logic [31:0]      r_hi;       // product high half / partial remainder
    logic [31:0]      r_lo;       // product low half (multiplier) / quotient
    logic             r_neg;      // operand signs differ
    logic             r_div_zero;
    logic             r_div_ovf;
    logic [31:0]      r_result;
    logic             r_exc;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic        w_start;
    logic        w_last;
    logic [32:0] w_as_a;
    logic [32:0] w_as_b;
    logic        w_as_sub;
    logic [32:0] w_as_sum;
    logic [32:0] w_acc;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [63:0] w_prod_s;
    logic [31:0] w_quot_s;
    logic [31:0] w_res_nxt;
    logic        w_exc_nxt;

    // A simultaneous MULT and DIV request is treated as no request at all
    assign w_start = ctrl_MULT ^ ctrl_DIV;
    assign w_last  = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // Shared adder: multiply adds the multiplicand to the high half,
    // divide subtracts the divisor from the shifted partial remainder.
    // ------------------------------------------------------------------
    assign w_as_a   = (r_op == OP_MUL) ? {1'b0, r_hi} : {r_hi, r_lo[31]};
    assign w_as_b   = {1'b0, r_mag};
    assign w_as_sub = (r_op == OP_DIV);

    multdiv_addsub u_addsub (
        .i_a   (w_as_a),
        .i_b   (w_as_b),
        .i_sub (w_as_sub),
        .o_sum (w_as_sum)
    );

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        w_acc    = {1'b0, r_hi};
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_op == OP_MUL) begin
            if (r_lo[0]) begin
                w_acc = w_as_sum;
            end
            // Shift {carry, hi, lo} right by one; multiplier bits drain out of lo
            w_hi_nxt = w_acc[32:1];
            w_lo_nxt = {w_acc[0], r_lo[31:1]};
        end else begin
            // Shifted remainder is below 2^32, so bit 32 of the difference
            // is a reliable borrow indicator
            if (!w_as_sum[32]) begin
                w_hi_nxt = w_as_sum[31:0];
                w_lo_nxt = {r_lo[30:0], 1'b1};
            end else begin
                w_hi_nxt = w_as_a[31:0];
                w_lo_nxt = {r_lo[30:0], 1'b0};
            end
        end
    end

    // Final sign correction and exception detection, applied to the values
    // produced by the last iteration
    assign w_prod_s = r_neg ? (~{w_hi_nxt, w_lo_nxt} + 64'd1) : {w_hi_nxt, w_lo_nxt};
    assign w_quot_s = r_neg ? (~w_lo_nxt + 32'd1) : w_lo_nxt;

    always_comb begin
        w_res_nxt = 32'd0;
        w_exc_nxt = 1'b0;
        if (r_op == OP_MUL) begin
            w_res_nxt = w_prod_s[31:0];
            w_exc_nxt = ~((&w_prod_s[63:31]) | ~(|w_prod_s[63:31]));
        end else if (r_div_zero) begin
            w_res_nxt = 32'd0;
            w_exc_nxt = 1'b1;
        end else begin
            w_res_nxt = w_quot_s;
            w_exc_nxt = r_div_ovf;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic. A start in any state (re)enters RUN.
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_RUN:  w_state_nxt = (r_cnt == CNT_LAST) ? ST_DONE : ST_RUN;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy           = (r_state == ST_RUN);
        data_resultRDY = (r_state == ST_DONE);
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_op       <= OP_MUL;
            r_mag      <= 32'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_result   <= 32'd0;
            r_exc      <= 1'b0;
        end else if (w_start) begin
            r_cnt      <= '0;
            r_op       <= ctrl_DIV ? OP_DIV : OP_MUL;
            r_hi       <= 32'd0;
            r_neg      <= data_operandA[31] ^ data_operandB[31];
            r_div_zero <= (data_operandB == 32'd0);
            r_div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            if (ctrl_DIV) begin
                r_mag <= f_abs(data_operandB);
                r_lo  <= f_abs(data_operandA);
            end else begin
                r_mag <= f_abs(data_operandA);
                r_lo  <= f_abs(data_operandB);
            end
        end else if (r_state == ST_RUN) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_res_nxt;
                r_exc    <= w_exc_nxt;
            end
        end
    end

endmodule : multdiv_unit
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_unit
//  Description : Directed self-checking bench for multdiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_vec;
    int n_err;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a start request for one edge; returns just after the start edge
    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        tick();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Called just after a start edge: busy for 32 cycles, RDY on the 32nd edge
    task automatic expect_done(input string tag, input logic [31:0] exp_res, input logic exp_exc);
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i < 32; i++) begin
            tick();
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_rdy_early"}, {31'd0, data_resultRDY}, 32'd0);
        end
        tick();
        chk({tag, "_rdy"}, {31'd0, data_resultRDY}, 32'd1);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_result"}, data_result, exp_res);
        chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        tick();
        chk({tag, "_rdy_off"}, {31'd0, data_resultRDY}, 32'd0);
        chk({tag, "_hold"}, data_result, exp_res);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_result", data_result, 32'd0);
        chk("rst_exc",    {31'd0, data_exception}, 32'd0);
        chk("rst_rdy",    {31'd0, data_resultRDY}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();

        // Multiplies: small signed, overflow, boundary cases
        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        expect_done("mul_7xm3", 32'hFFFF_FFEB, 1'b0);
        start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        expect_done("mul_ovf", 32'h0000_0000, 1'b1);
        start(1'b1, 1'b0, 32'h8000_0000, 32'd1);
        expect_done("mul_min", 32'h8000_0000, 1'b0);
        start(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_done("mul_min_neg", 32'h8000_0000, 1'b1);
        start(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_done("mul_m1xm1", 32'd1, 1'b0);

        // Divides: truncation toward zero, divide-by-zero, overflow
        start(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        expect_done("div_m100_7", 32'hFFFF_FFF2, 1'b0);
        start(1'b0, 1'b1, 32'd5, 32'd0);
        expect_done("div_zero", 32'd0, 1'b1);
        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_done("div_ovf", 32'h8000_0000, 1'b1);
        start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        expect_done("div_m7_m2", 32'd3, 1'b0);

        // Both start lines high in IDLE: ignored, outputs unchanged
        start(1'b1, 1'b1, 32'd9, 32'd9);
        for (int i = 0; i < 35; i++) begin
            chk("both_busy", {31'd0, busy}, 32'd0);
            chk("both_rdy",  {31'd0, data_resultRDY}, 32'd0);
            chk("both_res",  data_result, 32'd3);
            tick();
        end

        // Abort: MULT, then DIV 100/7 on the tenth edge after it
        start(1'b1, 1'b0, 32'd3, 32'd4);
        for (int i = 1; i < 10; i++) begin
            chk("abort_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        start(1'b0, 1'b1, 32'd100, 32'd7);
        expect_done("abort_div", 32'h0000_000E, 1'b0);

        // Reset in the middle of a multiply
        start(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (14) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_result", data_result, 32'd0);
        chk("mid_rst_exc",    {31'd0, data_exception}, 32'd0);
        chk("mid_rst_rdy",    {31'd0, data_resultRDY}, 32'd0);
        chk("mid_rst_busy",   {31'd0, busy}, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("post_rst_rdy",  {31'd0, data_resultRDY}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end

        // Fresh operation after reset release
        start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        expect_done("div_m7_2", 32'hFFFF_FFFD, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multdiv_unit
`default_nettype wire
